inst_fetch: RTL and testbench

- Consumer end of the program-counter interface. Takes the current fetch address from the pc block and drives back its `pause` input.
- Issues single-beat reads on the instruction-memory bus using a req/gnt + rvalid handshake.
- Buffers returned words with their addresses in a small FIFO, which presents {pc, instruction} to decode through a valid/ready handshake.
- Sits between pc and the decode stage. The redirect path is outside this block.

---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/inst_queue.sv | 71 +++++++
 rtl/inst_fetch.sv | 84 ++++++++
 tb/tb_inst_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: widths, queue depth and FSM encoding.
package inst_fetch_pkg;

  localparam int unsigned XLEN_WIDTH       = 32;
  localparam logic [XLEN_WIDTH-1:0] CPU_START_ADDR = '0;
  localparam int unsigned INST_QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO of {pc, instruction} pairs between the fetch FSM and decode.
module inst_queue
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = INST_QUEUE_DEPTH,
  parameter int unsigned XLEN  = XLEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [XLEN-1:0]          push_inst,
  input  logic                     pop,
  output logic [XLEN-1:0]          head_pc,
  output logic [XLEN-1:0]          head_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_inst = inst_mem_q[rd_ptr_q];

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        pc_mem_q[wr_ptr_q]   <= push_pc;
        inst_mem_q[wr_ptr_q] <= push_inst;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory reads driven by pc, results queued for decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = INST_QUEUE_DEPTH,
  parameter int unsigned XLEN  = XLEN_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_pause,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            accept, push, pop;

  assign mem_addr = {pc_in[XLEN-1:2], 2'b00};
  // Gating on rst keeps the bus quiet while reset is held.
  assign mem_req  = !rst && (state_q == S_REQ) && !full && !flush;
  assign accept   = mem_req && mem_gnt;
  assign pc_pause = !accept;

  assign push       = (state_q == S_RESP) && mem_rvalid && !flush;
  assign inst_valid = (count != '0);
  assign pop        = !empty && inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      inflight_pc_q <= '0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept) begin
            inflight_pc_q <= mem_addr;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (mem_rvalid)   state_q <= S_REQ;
          else if (flush)   state_q <= S_DROP;
        end
        S_DROP: begin
          if (mem_rvalid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  inst_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_pc   (inflight_pc_q),
    .push_inst (mem_rdata),
    .pop       (pop),
    .head_pc   (inst_pc),
    .head_inst (inst_out),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: pc and memory environment, queue-level reference model, directed scenarios.
module tb_inst_fetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] KEY   = 32'h1357_9BDF;
  localparam logic [31:0] DEAD  = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in;
  logic        pc_pause;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int n_vec = 0;
  int n_err = 0;

  // Environment: pc block and a memory with programmable grant delay and read latency.
  int          gnt_delay = 0;
  int          rlat      = 1;
  bit          ovr       = 1'b0;
  bit          stale_rv  = 1'b0;
  logic [31:0] pc;
  int          req_wait;
  int          rv_timer;
  logic [31:0] resp_addr;

  assign pc_in      = pc;
  assign mem_gnt    = (req_wait >= gnt_delay);
  assign mem_rvalid = (rv_timer == 1) || stale_rv;
  assign mem_rdata  = (ovr || stale_rv) ? DEAD : (resp_addr ^ KEY);

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= 32'h0;
      req_wait  <= 0;
      rv_timer  <= 0;
      resp_addr <= 32'h0;
    end else begin
      if (!pc_pause) pc <= pc + 32'd4;
      if (!mem_req || mem_gnt) req_wait <= 0;
      else                     req_wait <= req_wait + 1;
      if (mem_req && mem_gnt) begin
        rv_timer  <= rlat;
        resp_addr <= mem_addr;
      end else if (rv_timer > 0) begin
        rv_timer <= rv_timer - 1;
      end
    end
  end

  inst_fetch #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_pause   (pc_pause),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of fetched words plus one outstanding-request flag.
  ent_t        m_q[$];
  ent_t        cap[$];
  bit          m_out  = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_addr = 32'h0;
  bit          saw_dead = 1'b0;

  initial begin
    bit exp_req, acc, pushm, popm;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pc_pause", 32'(pc_pause), 32'd1);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        m_q.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else begin
        exp_req = !m_out && (m_q.size() < DEPTH) && !flush;
        acc     = exp_req && mem_gnt;
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) check("mem_addr", mem_addr, pc & ~32'h3);
        check("pc_pause", 32'(pc_pause), 32'(!acc));
        check("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
          check("inst_pc", inst_pc, m_q[0].pc);
          check("inst_out", inst_out, m_q[0].data);
        end
        if (inst_valid && inst_ready && !flush) cap.push_back('{inst_pc, inst_out});
        if (inst_valid && inst_out == DEAD) saw_dead = 1'b1;

        popm  = (m_q.size() != 0) && inst_ready && !flush;
        pushm = m_out && mem_rvalid && !flush && !m_drop;
        if (m_out && mem_rvalid) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else if (m_out && flush) begin
          m_drop = 1'b1;
        end
        if (flush) begin
          m_q.delete();
        end else begin
          if (popm) void'(m_q.pop_front());
          if (pushm) m_q.push_back('{m_addr, mem_rdata});
        end
        if (acc) begin
          m_out  = 1'b1;
          m_addr = pc & ~32'h3;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    flush    = 1'b0;
    stale_rv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cap.delete();
  endtask

  task automatic check_cap(input int idx, input logic [31:0] epc, input logic [31:0] edata);
    check($sformatf("cap%0d_present", idx), 32'(cap.size() > idx), 32'd1);
    if (cap.size() > idx) begin
      check($sformatf("cap%0d_pc", idx), cap[idx].pc, epc);
      check($sformatf("cap%0d_data", idx), cap[idx].data, edata);
    end
  endtask

  initial begin
    // Streaming fetch with 1-cycle grant and response.
    gnt_delay  = 0;
    rlat       = 1;
    inst_ready = 1'b1;
    do_reset();
    repeat (8) @(negedge clk);
    check_cap(0, 32'h0, 32'h1357_9BDF);
    check_cap(1, 32'h4, 32'h1357_9BDB);
    check_cap(2, 32'h8, 32'h1357_9BD7);

    // Grant held off for three cycles.
    gnt_delay = 3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #3;
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_addr", mem_addr, 32'h0);
      check("stall_pause", 32'(pc_pause), 32'd1);
      @(negedge clk);
    end
    #3;
    check("gnt_pause", 32'(pc_pause), 32'd0);
    @(negedge clk);
    #3;
    check("gnt_pc", pc, 32'h4);
    gnt_delay = 0;

    // Back-pressure fills the queue, one pop restarts fetch at 0x8.
    inst_ready = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    inst_ready = 1'b1;
    #3;
    check("full_req", 32'(mem_req), 32'd0);
    check("full_pc", pc, 32'h8);
    check("full_head", inst_pc, 32'h0);
    @(negedge clk);
    inst_ready = 1'b0;
    #3;
    check("refill_req", 32'(mem_req), 32'd1);
    check("refill_addr", mem_addr, 32'h8);

    // Flush while a response is outstanding drops it.
    rlat       = 3;
    ovr        = 1'b1;
    inst_ready = 1'b1;
    saw_dead   = 1'b0;
    do_reset();
    @(negedge clk);
    flush = 1'b1;
    #3;
    check("drop_flush_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("drop_wait_req", 32'(mem_req), 32'd0);
    repeat (2) @(negedge clk);
    ovr  = 1'b0;
    rlat = 1;
    #3;
    check("drop_next_req", 32'(mem_req), 32'd1);
    check("drop_next_addr", mem_addr, 32'h4);
    repeat (4) @(negedge clk);
    check("drop_no_dead", 32'(saw_dead), 32'd0);

    // Flush with a full queue and a simultaneous pop.
    inst_ready = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    flush      = 1'b1;
    inst_ready = 1'b1;
    #3;
    check("fl_pre_valid", 32'(inst_valid), 32'd1);
    @(negedge clk);
    flush      = 1'b0;
    inst_ready = 1'b0;
    #3;
    check("fl_valid", 32'(inst_valid), 32'd0);
    check("fl_req", 32'(mem_req), 32'd1);
    check("fl_addr", mem_addr, 32'h8);

    // Reset pulse with a response in flight, then a stale rvalid.
    inst_ready = 1'b0;
    saw_dead   = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    #3;
    check("pre_rst_out", inst_out, 32'h1357_9BDF);
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_out", inst_out, 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    stale_rv   = 1'b1;
    inst_ready = 1'b1;
    cap.delete();
    #3;
    check("post_rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    stale_rv = 1'b0;
    repeat (3) @(negedge clk);
    check_cap(0, 32'h0, 32'h1357_9BDF);
    check("stale_no_dead", 32'(saw_dead), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
